wrap_sequencer: RTL

Autonomous loopback self-test sequencer that generates the `test_driver` word and consumes `test_receiver` from the parallel-channel wrap stage.
- Enables the frontend, then walks a single 1 across driver bits 1..19 and compares each returned word against the expected wrap.
- Records a per-bit failure mask, an error count and the first failing word.
- Sits between the host/CSR block and the channel "A" wrap stage, so bring-up runs without software bit-banging.

---
 rtl/wrap_pkg.sv | 21 ++
 rtl/wrap_settle_timer.sv | 34 +++
 rtl/wrap_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wrap_pkg.sv
// wrap_pkg: shared constants and state type for the wrap loopback sequencer.
package wrap_pkg;

    localparam logic [31:0] WRAP_EXPECT_MASK = 32'h000F_FFFE;
    localparam int          FRONTEND_EN_BIT  = 31;
    localparam int          WRAP_FIRST_BIT   = 1;
    localparam int          WRAP_LAST_BIT    = 19;

    typedef enum logic [2:0] {
        IDLE,
        ENABLE,
        DRIVE,
        CHECK,
        DONE
    } wrap_state_e;

    function automatic logic [31:0] wrap_expect(input logic [31:0] drv);
        return drv & WRAP_EXPECT_MASK;
    endfunction

endpackage

// File: rtl/wrap_settle_timer.sv
// wrap_settle_timer: loadable down-counter; tc is high while the count is zero.
// Load takes priority so a new interval can start on the terminal cycle.
module wrap_settle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/wrap_sequencer.sv
// wrap_sequencer: walking-1 loopback self-test of the channel A wrap stage.
// Optional walking-0 second pass when WRAP_SEQ_WALKING_ZERO_EN is defined.
module wrap_sequencer
    import wrap_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ENABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] test_driver,
    input  logic [31:0] test_receiver,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [19:0] fail_mask,
    output logic [5:0]  error_count,
    output logic [4:0]  first_fail_index,
    output logic [31:0] first_fail_word
);

    localparam int CNT_MAX = (ENABLE_CYCLES > SETTLE_CYCLES) ?
                             ENABLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0] EN_WORD = 32'(1) << FRONTEND_EN_BIT;

    wrap_state_e state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [19:0] mask_q, mask_d;
    logic [5:0]  err_q, err_d;
    logic [4:0]  fidx_q, fidx_d;
    logic [31:0] fword_q, fword_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tc;
    logic [31:0]      onehot;
    logic [31:0]      pattern;
    logic [31:0]      drv;
    logic             mismatch;
    logic             last_pass;

    assign onehot = 32'(1) << idx_q;

`ifdef WRAP_SEQ_WALKING_ZERO_EN
    logic phase_q, phase_d;
    assign pattern = phase_q ? ((EN_WORD | WRAP_EXPECT_MASK) & ~onehot)
                             : (EN_WORD | onehot);
    assign last_pass = phase_q;
`else
    assign pattern = EN_WORD | onehot;
    assign last_pass = 1'b1;
`endif

    wrap_settle_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .load_val(load_val),
        .tc      (tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        fword_d  = fword_q;
        done_d   = done_q;
        pass_d   = pass_q;
        load     = 1'b0;
        load_val = '0;
        drv      = '0;
        busy     = 1'b0;
        mismatch = 1'b0;
`ifdef WRAP_SEQ_WALKING_ZERO_EN
        phase_d  = phase_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = ENABLE;
                    mask_d   = '0;
                    err_d    = '0;
                    fidx_d   = '0;
                    fword_d  = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    load     = 1'b1;
                    load_val = EN_LOAD;
`ifdef WRAP_SEQ_WALKING_ZERO_EN
                    phase_d  = 1'b0;
`endif
                end
            end
            ENABLE: begin
                drv  = EN_WORD;
                busy = 1'b1;
                if (tc) begin
                    state_d  = DRIVE;
                    idx_d    = 5'(WRAP_FIRST_BIT);
                    load     = 1'b1;
                    load_val = SET_LOAD;
                end
            end
            DRIVE: begin
                drv  = pattern;
                busy = 1'b1;
                if (tc) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                drv      = pattern;
                busy     = 1'b1;
                mismatch = (test_receiver != wrap_expect(pattern));
                if (mismatch) begin
                    mask_d[idx_q] = 1'b1;
                    if (err_q != 6'd63) begin
                        err_d = err_q + 6'd1;
                    end
                    // err_q still zero means no earlier mismatch this run
                    if (err_q == '0) begin
                        fidx_d  = idx_q;
                        fword_d = test_receiver;
                    end
                end
                if (idx_q == 5'(WRAP_LAST_BIT) && last_pass) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d  = DRIVE;
                    load     = 1'b1;
                    load_val = SET_LOAD;
                    if (idx_q == 5'(WRAP_LAST_BIT)) begin
                        idx_d = 5'(WRAP_FIRST_BIT);
`ifdef WRAP_SEQ_WALKING_ZERO_EN
                        phase_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && busy) begin
            state_d = IDLE;
            done_d  = 1'b0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fword_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fword_q <= fword_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef WRAP_SEQ_WALKING_ZERO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    assign test_driver      = drv;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_mask        = mask_q;
    assign error_count      = err_q;
    assign first_fail_index = fidx_q;
    assign first_fail_word  = fword_q;

endmodule
